// File: rtl/count_ones.sv
// Set-bit counter: total popcount (CONTINUOUS=0) or run of ones from bit 0 (CONTINUOUS=1),
// with a registered copy. Define COUNT_ONE_ASSERT_EN to compile the embedded property checks.
module count_ones #(
   parameter int CONTINUOUS = 0,
   parameter int WIDTH      = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [WIDTH-1:0]         data_in,
   output logic [$clog2(WIDTH):0]   sum,
   output logic [$clog2(WIDTH):0]   sum_r
);

   localparam int L = $clog2(WIDTH);
   localparam int P = 1 << L;

   logic [WIDTH-1:0] src;
   logic [P-1:0]     bits;

   generate
      if (CONTINUOUS != 0) begin : g_run
         logic [WIDTH-1:0] chain;
         // Bit i survives only if every bit below it is set, so the tree counts the leading run.
         always_comb begin
            logic acc;
            acc   = 1'b1;
            chain = '0;
            for (int i = 0; i < WIDTH; i++) begin
               acc      = acc & data_in[i];
               chain[i] = acc;
            end
         end
         assign src = chain;
      end else begin : g_pop
         assign src = data_in;
      end
   endgenerate

   always_comb begin
      bits             = '0;
      bits[WIDTH-1:0]  = src;
   end

   // Level k holds P>>k partial counts, each k+1 bits wide.
   for (genvar k = 0; k <= L; k++) begin : g_lvl
      localparam int N  = P >> k;
      localparam int BW = k + 1;
      logic [N*BW-1:0] v;
      if (k == 0) begin : g_leaf
         assign v = bits;
      end else begin : g_add
         for (genvar j = 0; j < N; j++) begin : g_node
            assign v[j*BW +: BW] = {1'b0, g_lvl[k-1].v[(2*j)*(BW-1) +: BW-1]}
                                 + {1'b0, g_lvl[k-1].v[(2*j+1)*(BW-1) +: BW-1]};
         end
      end
   end

   assign sum = g_lvl[L].v;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) sum_r <= '0;
      else      sum_r <= sum;
   end

`ifdef COUNT_ONE_ASSERT_EN
   localparam logic [L:0] SUM_MAX = (L+1)'(WIDTH);

   a_sum_range: assert property (@(posedge clk) sum <= SUM_MAX)
      else $error("count_ones: sum %0d exceeds WIDTH", sum);

   a_sum_r_track: assert property (@(posedge clk) disable iff (!rst)
                                   ($past(rst) && rst) |-> (sum_r == $past(sum)))
      else $error("count_ones: sum_r does not follow previous sum");

   if (CONTINUOUS != 0) begin : g_run_chk
      logic [WIDTH-1:0] shifted;
      assign shifted = data_in >> sum;
      a_run_stop: assert property (@(posedge clk) (sum < SUM_MAX) |-> !shifted[0])
         else $error("count_ones: data_in[sum] is not zero");
   end
`endif

endmodule

// File: tb/tb_count_ones.sv
// Directed checks of count_ones in both modes across widths 1, 3 and 8, plus registered path
// and asynchronous reset behaviour, followed by a short random sweep against local models.
module tb_count_ones;

   logic       clk;
   logic       rst;
   logic [2:0] d3;
   logic [0:0] d1;
   logic [7:0] d8;

   logic [2:0] s_c0w3, r_c0w3, s_c1w3, r_c1w3;
   logic [0:0] s_c0w1, r_c0w1, s_c1w1, r_c1w1;
   logic [3:0] s_c0w8, r_c0w8, s_c1w8, r_c1w8;

   int n_tests = 0;
   int n_fail  = 0;

   count_ones #(.CONTINUOUS(0), .WIDTH(3)) u_c0w3 (.clk(clk), .rst(rst), .data_in(d3), .sum(s_c0w3), .sum_r(r_c0w3));
   count_ones #(.CONTINUOUS(1), .WIDTH(3)) u_c1w3 (.clk(clk), .rst(rst), .data_in(d3), .sum(s_c1w3), .sum_r(r_c1w3));
   count_ones #(.CONTINUOUS(0), .WIDTH(1)) u_c0w1 (.clk(clk), .rst(rst), .data_in(d1), .sum(s_c0w1), .sum_r(r_c0w1));
   count_ones #(.CONTINUOUS(1), .WIDTH(1)) u_c1w1 (.clk(clk), .rst(rst), .data_in(d1), .sum(s_c1w1), .sum_r(r_c1w1));
   count_ones #(.CONTINUOUS(0), .WIDTH(8)) u_c0w8 (.clk(clk), .rst(rst), .data_in(d8), .sum(s_c0w8), .sum_r(r_c0w8));
   count_ones #(.CONTINUOUS(1), .WIDTH(8)) u_c1w8 (.clk(clk), .rst(rst), .data_in(d8), .sum(s_c1w8), .sum_r(r_c1w8));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int ref_pop(input logic [7:0] v);
      int n;
      n = 0;
      for (int i = 0; i < 8; i++) if (v[i]) n++;
      return n;
   endfunction

   function automatic int ref_run(input logic [7:0] v);
      int n;
      n = 0;
      for (int i = 0; i < 8; i++) begin
         if (!v[i]) break;
         n++;
      end
      return n;
   endfunction

   int exp_pop3 [8] = '{0, 1, 1, 2, 1, 2, 2, 3};
   int exp_run3 [8] = '{0, 1, 0, 2, 0, 1, 0, 3};

   initial begin
      int e_pop, e_run;
      rst = 1'b0;
      d3  = 3'b000;
      d1  = 1'b0;
      d8  = 8'h00;
      #2;
      check("reset_sum_r_w3", int'(r_c0w3), 0);
      check("reset_sum_r_w8", int'(r_c1w8), 0);

      for (int v = 0; v < 8; v++) begin
         d3 = 3'(v);
         #10;
         check($sformatf("pop3_%0d", v), int'(s_c0w3), exp_pop3[v]);
         check($sformatf("run3_%0d", v), int'(s_c1w3), exp_run3[v]);
      end
      check("sum_r_held_in_reset", int'(r_c0w3), 0);

      @(negedge clk);
      rst = 1'b1;
      d3  = 3'b111;
      @(posedge clk); #1;
      check("reg_111", int'(r_c0w3), 3);
      @(negedge clk);
      d3 = 3'b010;
      #1;
      check("reg_holds_until_edge", int'(r_c0w3), 3);
      @(posedge clk); #1;
      check("reg_010", int'(r_c0w3), 1);
      @(negedge clk);
      d3 = 3'b111;
      @(posedge clk); #1;
      check("reg_111_again", int'(r_c0w3), 3);
      #2;
      rst = 1'b0;
      #1;
      check("async_reset_sum_r", int'(r_c0w3), 0);
      d3 = 3'b101;
      #1;
      check("sum_tracks_in_reset", int'(s_c0w3), 2);
      @(posedge clk); #1;
      check("sum_r_stays_reset", int'(r_c0w3), 0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      check("first_edge_after_reset", int'(r_c0w3), 2);

      d1 = 1'b1;
      #1;
      check("w1_pop_1", int'(s_c0w1), 1);
      check("w1_run_1", int'(s_c1w1), 1);
      d1 = 1'b0;
      #1;
      check("w1_pop_0", int'(s_c0w1), 0);
      check("w1_run_0", int'(s_c1w1), 0);

      d8 = 8'h7F; #1;
      check("w8_run_7f", int'(s_c1w8), 7);
      check("w8_pop_7f", int'(s_c0w8), 7);
      d8 = 8'hFF; #1;
      check("w8_run_ff", int'(s_c1w8), 8);
      check("w8_pop_ff", int'(s_c0w8), 8);
      d8 = 8'hAA; #1;
      check("w8_pop_aa", int'(s_c0w8), 4);
      check("w8_run_aa", int'(s_c1w8), 0);
      d8 = 8'h0B; #1;
      check("w8_run_0b", int'(s_c1w8), 2);
      check("w8_pop_0b", int'(s_c0w8), 3);
      d8 = 8'h00; #1;
      check("w8_pop_00", int'(s_c0w8), 0);

      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         d8 = 8'($urandom);
         d3 = 3'($urandom);
         e_pop = ref_pop(d8);
         e_run = ref_run(d8);
         #1;
         check("rnd_pop8", int'(s_c0w8), e_pop);
         check("rnd_run8", int'(s_c1w8), e_run);
         check("rnd_pop3", int'(s_c0w3), exp_pop3[int'(d3)]);
         check("rnd_run3", int'(s_c1w3), exp_run3[int'(d3)]);
         @(posedge clk); #1;
         check("rnd_pop8_r", int'(r_c0w8), e_pop);
         check("rnd_run8_r", int'(r_c1w8), e_run);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
